// File: rtl/hamming_ctrl_pkg.sv
// Shared types and default constants for the Hamming scrub controller.
// Contents:
//   state_e        - controller FSM state encoding
//   ScrubPeriodDef - default cycles between scrub checks
//   SynWDef        - default syndrome width
//   ErrWDef        - default correction counter width
//   Timeout        - WAIT_CHK watchdog length (used only with SCRUB_TIMEOUT_EN)
//   TimerW         - width of the scrub reload counter (covers periods up to 65535)
package hamming_ctrl_pkg;

  localparam int unsigned ScrubPeriodDef = 64;
  localparam int unsigned SynWDef        = 5;
  localparam int unsigned ErrWDef        = 8;
  localparam int unsigned Timeout        = 16;
  localparam int unsigned TimerW         = 16;

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StCheck,
    StWaitChk,
    StCorrect,
    StFault
  } state_e;

endpackage

// File: rtl/scrub_timer.sv
// Reload down-counter that paces scrub checks.
// Counts down while run is high; when it reaches zero it raises expire for that
// cycle and reloads SCRUB_PERIOD-1. rst (synchronous, active-high) also reloads.
// Ports:
//   clk    - clock
//   rst    - synchronous reload/reset
//   run    - count enable
//   expire - high in the cycle the count is zero while running
module scrub_timer
  import hamming_ctrl_pkg::*;
#(
  parameter int unsigned SCRUB_PERIOD = ScrubPeriodDef
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expire
);

  localparam logic [TimerW-1:0] Reload = TimerW'(SCRUB_PERIOD - 1);

  logic [TimerW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= Reload;
    end else if (run) begin
      cnt_q <= (cnt_q == '0) ? Reload : cnt_q - TimerW'(1);
    end
  end

  assign expire = run && (cnt_q == '0);

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// Control FSM for a Hamming-protected counter: arbitrates increment requests
// against periodic scrub checks, writes back single-bit corrections and parks in
// FAULT on an uncorrectable error until clr_fault.
// Optional build macro SCRUB_TIMEOUT_EN adds a watchdog that moves WAIT_CHK to
// FAULT after Timeout cycles without chk_valid.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   cnt_req    - level request to increment       cnt_en/cnt_ack - increment enable / accept
//   chk_req    - one-cycle recompute request      chk_valid      - qualifies syndrome/dbl_err
//   syndrome   - Hamming syndrome (0 = clean)     dbl_err        - uncorrectable error flag
//   corr_en    - one-cycle correction write-back  clr_fault      - leave FAULT
//   corr_cnt   - saturating correction count      alarm / busy   - in FAULT / not IDLE
module hamming_scrub_ctrl
  import hamming_ctrl_pkg::*;
#(
  parameter int unsigned SCRUB_PERIOD = ScrubPeriodDef,
  parameter int unsigned SYN_W        = SynWDef,
  parameter int unsigned ERR_W        = ErrWDef
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_req,
  output logic             cnt_en,
  output logic             cnt_ack,
  output logic             chk_req,
  input  logic             chk_valid,
  input  logic [SYN_W-1:0] syndrome,
  input  logic             dbl_err,
  output logic             corr_en,
  input  logic             clr_fault,
  output logic [ERR_W-1:0] corr_cnt,
  output logic             alarm,
  output logic             busy
);

  state_e            state_q, state_d;
  logic              scrub_pend_q, scrub_pend_d;
  logic [ERR_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic              expire;
  logic              timer_run;
  logic              timer_rst;

  // Leaving FAULT restarts the scrub schedule from a full period.
  assign timer_run = (state_q != StFault);
  assign timer_rst = rst | ((state_q == StFault) & clr_fault);

  scrub_timer #(
    .SCRUB_PERIOD(SCRUB_PERIOD)
  ) u_scrub_timer (
    .clk   (clk),
    .rst   (timer_rst),
    .run   (timer_run),
    .expire(expire)
  );

`ifdef SCRUB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(Timeout) + 1;

  logic [WdW-1:0] wd_q;
  logic           wd_timeout;

  // Counts cycles spent in WAIT_CHK; zero on the first WAIT_CHK cycle.
  always_ff @(posedge clk) begin
    if (rst || (state_q != StWaitChk)) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WdW'(1);
    end
  end

  assign wd_timeout = (wd_q == WdW'(Timeout - 1));
`endif

  always_comb begin
    scrub_pend_d = scrub_pend_q;
    if (state_q == StCheck) scrub_pend_d = 1'b0;
    // A fresh expiry wins over the clear; repeated expiries just stay pending.
    if (expire) scrub_pend_d = 1'b1;
    if ((state_q == StFault) && clr_fault) scrub_pend_d = 1'b0;
  end

  always_comb begin
    corr_cnt_d = corr_cnt_q;
    if ((state_q == StCorrect) && (corr_cnt_q != '1)) corr_cnt_d = corr_cnt_q + ERR_W'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    cnt_ack = 1'b0;
    chk_req = 1'b0;
    corr_en = 1'b0;
    alarm   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (scrub_pend_q)  state_d = StCheck;
        else if (cnt_req)  state_d = StCount;
      end
      StCount: begin
        // Only ack a request that is still present.
        cnt_en  = cnt_req;
        cnt_ack = cnt_req;
        if (!cnt_req || scrub_pend_q) state_d = StIdle;
      end
      StCheck: begin
        chk_req = 1'b1;
        state_d = StWaitChk;
      end
      StWaitChk: begin
        if (chk_valid) begin
          if (dbl_err)            state_d = StFault;
          else if (|syndrome)     state_d = StCorrect;
          else                    state_d = StIdle;
        end
`ifdef SCRUB_TIMEOUT_EN
        else if (wd_timeout) begin
          state_d = StFault;
        end
`endif
      end
      StCorrect: begin
        corr_en = 1'b1;
        state_d = StIdle;
      end
      StFault: begin
        alarm = 1'b1;
        if (clr_fault) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      scrub_pend_q <= 1'b0;
      corr_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      scrub_pend_q <= scrub_pend_d;
      corr_cnt_q   <= corr_cnt_d;
    end
  end

  assign corr_cnt = corr_cnt_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Directed self-checking bench for hamming_scrub_ctrl with SCRUB_PERIOD=16.
// A 3-bit correction counter keeps the saturation case short.
module tb_hamming_scrub_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cnt_req = 1'b0;
  logic       cnt_en, cnt_ack, chk_req, corr_en, alarm, busy;
  logic       chk_valid = 1'b0;
  logic [4:0] syndrome = '0;
  logic       dbl_err = 1'b0;
  logic       clr_fault = 1'b0;
  logic [2:0] corr_cnt;

  int n_vec = 0;
  int n_mis = 0;
  int excl_viol = 0;

  hamming_scrub_ctrl #(
    .SCRUB_PERIOD(16),
    .SYN_W       (5),
    .ERR_W       (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt_req  (cnt_req),
    .cnt_en   (cnt_en),
    .cnt_ack  (cnt_ack),
    .chk_req  (chk_req),
    .chk_valid(chk_valid),
    .syndrome (syndrome),
    .dbl_err  (dbl_err),
    .corr_en  (corr_en),
    .clr_fault(clr_fault),
    .corr_cnt (corr_cnt),
    .alarm    (alarm),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cnt_en && corr_en) excl_viol++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "bench timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cnt_req   = 1'b0;
    chk_valid = 1'b0;
    syndrome  = '0;
    dbl_err   = 1'b0;
    clr_fault = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Waits for chk_req (sampled on negedge), then steps into the WAIT_CHK cycle.
  // n = cycles elapsed before chk_req was seen; ack = cnt_ack in the CHECK cycle.
  task automatic wait_chk(output int n, output logic ack);
    logic found;
    found = 1'b0;
    n     = 0;
    ack   = 1'b0;
    while (!found && n < 60) begin
      @(negedge clk);
      if (chk_req) begin
        found = 1'b1;
        ack   = cnt_ack;
      end else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check_eq("chk_req_seen", found, 1);
    @(posedge clk);
    #1;
  endtask

  // Presents one check result for a single cycle from WAIT_CHK.
  task automatic apply_chk(input logic [4:0] syn, input logic dbl);
    chk_valid = 1'b1;
    syndrome  = syn;
    dbl_err   = dbl;
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
    syndrome  = '0;
    dbl_err   = 1'b0;
  endtask

  initial begin
    int   n, pulses, acks, chks, cnt_a, cnt_b;
    logic ack;

    // Reset state
    do_reset();
    @(negedge clk);
    check_eq("rst_outputs", {busy, alarm, cnt_en, cnt_ack, chk_req, corr_en}, 0);
    check_eq("rst_corr_cnt", corr_cnt, 0);

    // cnt_req held 10 cycles: IDLE in cycle 1, COUNT pulses in cycles 2..10
    do_reset();
    cnt_req = 1'b1;
    pulses = 0; acks = 0; chks = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 10) cnt_req = 1'b0;
      @(negedge clk);
      pulses += int'(cnt_en);
      acks   += int'(cnt_ack);
      chks   += int'(chk_req);
      @(posedge clk);
      #1;
    end
    check_eq("burst_cnt_en", pulses, 9);
    check_eq("burst_cnt_ack", acks, 9);
    check_eq("burst_no_chk", chks, 0);
    check_eq("burst_idle", busy, 0);

    // Continuous cnt_req: scrub pre-empts counting; expiry at cycle 16, then
    // scrub_pend registration and COUNT->IDLE->CHECK put chk_req at cycle 19.
    do_reset();
    cnt_req = 1'b1;
    wait_chk(n, ack);
    check_eq("chk_rise_window", ((n + 1) >= 16) && ((n + 1) <= 19), 1);
    check_eq("no_ack_in_check", ack, 0);
    acks = 0; cnt_a = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      acks  += int'(cnt_ack);
      cnt_a += int'(busy);
      @(posedge clk);
      #1;
    end
    check_eq("no_ack_in_wait", acks, 0);
    check_eq("wait_busy", cnt_a, 3);
    apply_chk(5'd0, 1'b0);
    @(negedge clk);
    check_eq("clean_to_idle", {busy, cnt_ack}, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("ack_resumes", cnt_ack, 1);
    cnt_req = 1'b0;

    // Single-bit error: one corr_en pulse, corr_cnt 0 -> 1, back to IDLE
    do_reset();
    wait_chk(n, ack);
    chk_valid = 1'b1;
    syndrome  = 5'b00111;
    @(negedge clk);
    check_eq("corr_not_early", corr_en, 0);
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
    syndrome  = '0;
    @(negedge clk);
    check_eq("corr_en_pulse", corr_en, 1);
    check_eq("corr_cnt_before", corr_cnt, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("corr_en_done", corr_en, 0);
    check_eq("corr_cnt_one", corr_cnt, 1);
    check_eq("corr_back_idle", busy, 0);

    // Eight more corrections: 3-bit counter saturates at 7 rather than wrapping
    for (int k = 0; k < 8; k++) begin
      wait_chk(n, ack);
      apply_chk(5'd1, 1'b0);
    end
    @(posedge clk);
    #1;
    check_eq("corr_cnt_sat", corr_cnt, 7);

    // Double error (with a nonzero syndrome): FAULT blocks everything for 20 cycles
    do_reset();
    cnt_req = 1'b1;
    wait_chk(n, ack);
    apply_chk(5'b10000, 1'b1);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt_a += int'(alarm);
      cnt_b += int'(cnt_en | cnt_ack | chk_req | corr_en);
      @(posedge clk);
      #1;
    end
    check_eq("fault_alarm", cnt_a, 20);
    check_eq("fault_strobes", cnt_b, 0);
    check_eq("fault_no_corr", corr_cnt, 0);
    clr_fault = 1'b1;
    @(posedge clk);
    #1;
    clr_fault = 1'b0;
    @(negedge clk);
    check_eq("clr_alarm", alarm, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("clr_cnt_resume", cnt_en, 1);
    cnt_req = 1'b0;

    // chk_valid withheld in WAIT_CHK
    do_reset();
    wait_chk(n, ack);
`ifdef SCRUB_TIMEOUT_EN
    begin
      logic seen;
      int   j;
      seen = 1'b0;
      j    = 0;
      while (!seen && j < 40) begin
        @(negedge clk);
        if (alarm) seen = 1'b1;
        else begin
          @(posedge clk);
          #1;
          j++;
        end
      end
      check_eq("wd_fault_seen", seen, 1);
      check_eq("wd_fault_cycle", j, 16);
    end
`else
    cnt_a = 0; cnt_b = 0; chks = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt_a += int'(busy);
      cnt_b += int'(alarm);
      chks  += int'(cnt_en | chk_req | corr_en);
      @(posedge clk);
      #1;
    end
    check_eq("hold_busy", cnt_a, 100);
    check_eq("hold_no_alarm", cnt_b, 0);
    check_eq("hold_no_strobe", chks, 0);
    // Many expiries happened while waiting; only one scrub may follow.
    // Clean result lands IDLE at cycle 120; next expiry is cycle 128.
    apply_chk(5'd0, 1'b0);
    chk_valid = 1'b1;
    chks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chks += int'(chk_req);
      @(posedge clk);
      #1;
    end
    chk_valid = 1'b0;
    check_eq("one_pending_scrub", chks, 1);
`endif

    // Reset during WAIT_CHK
    do_reset();
    cnt_req = 1'b1;
    wait_chk(n, ack);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_in_wait", {busy, alarm, cnt_en, cnt_ack, chk_req, corr_en}, 0);
    rst = 1'b0;
    cnt_req = 1'b0;

    // Reset during CORRECT (after one completed correction)
    do_reset();
    wait_chk(n, ack);
    apply_chk(5'd7, 1'b0);
    @(posedge clk);
    #1;
    wait_chk(n, ack);
    apply_chk(5'd3, 1'b0);
    check_eq("pre_rst_corr_en", corr_en, 1);
    check_eq("pre_rst_corr_cnt", corr_cnt, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_in_correct", {busy, alarm, cnt_en, cnt_ack, chk_req, corr_en}, 0);
    check_eq("rst_clears_cnt", corr_cnt, 0);
    rst = 1'b0;

    check_eq("cnt_corr_exclusive", excl_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
